// File: rtl/contador_comparador_n_pkg.sv
// contador_comparador_n_pkg: shared direction codes and display digit width
package contador_comparador_n_pkg;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int   DIGIT_W  = 7;
endpackage

// File: rtl/contador_comparador_n_mod.sv
// contador_mod_n: loadable up/down modulo counter with wrap/saturate ends
module contador_mod_n
    import contador_comparador_n_pkg::*;
#(
    parameter int N      = 8,
    parameter int MODULO = 200,
    parameter bit WRAP   = 1'b1
) (
    input  logic         clock,
    input  logic         zera,
    input  logic         carrega,
    input  logic         conta,
    input  logic         desce,
    input  logic [N-1:0] chaves,
    output logic [N-1:0] q,
    output logic [N-1:0] q_next,
    output logic         step,
    output logic         fim
);
    localparam logic [N-1:0] MAX = N'(MODULO - 1);
    logic         at_end;
    logic [N-1:0] up, dn, load;
    always_comb begin
        at_end = (desce == DIR_DOWN) ? (q == '0) : (q == MAX);
        fim    = conta & at_end;
        up     = (q == MAX) ? (WRAP ? '0 : q) : q + N'(1);
        dn     = (q == '0) ? (WRAP ? MAX : q) : q - N'(1);
        load   = (32'(chaves) < MODULO) ? chaves : MAX;
        step   = conta & ~carrega & (WRAP | ~at_end);
        q_next = carrega ? load : conta ? ((desce == DIR_DOWN) ? dn : up) : q;
    end
    always_ff @(posedge clock)
        q <= zera ? '0 : q_next;
endmodule

// File: rtl/hexa7seg.sv
// hexa7seg: nibble to active-high 7-segment code, bit order gfedcba
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);
    always_comb begin
        display = 7'h00;
        case (hexa)
            4'h0: display = 7'h3F;
            4'h1: display = 7'h06;
            4'h2: display = 7'h5B;
            4'h3: display = 7'h4F;
            4'h4: display = 7'h66;
            4'h5: display = 7'h6D;
            4'h6: display = 7'h7D;
            4'h7: display = 7'h07;
            4'h8: display = 7'h7F;
            4'h9: display = 7'h6F;
            4'hA: display = 7'h77;
            4'hB: display = 7'h7C;
            4'hC: display = 7'h39;
            4'hD: display = 7'h5E;
            4'hE: display = 7'h79;
            4'hF: display = 7'h71;
            default: display = 7'h00;
        endcase
    end
endmodule

// File: rtl/contador_comparador_n.sv
// contador_comparador_n: modulo counter, compare against chaves, reach pulse, 7-seg debug
module contador_comparador_n
    import contador_comparador_n_pkg::*;
#(
    parameter int N      = 8,
    parameter int MODULO = 200,
    parameter bit WRAP   = 1'b1
) (
    input  logic                   clock,
    input  logic                   zera,
    input  logic                   carrega,
    input  logic                   conta,
    input  logic                   desce,
    input  logic [N-1:0]           chaves,
    output logic                   menor,
    output logic                   maior,
    output logic                   igual,
    output logic                   fim,
    output logic                   alcancou,
    output logic [DIGIT_W*N/4-1:0] db_contagem
);
    if (N % 4 != 0 || N < 4 || N > 16 || MODULO < 2 || MODULO > 2 ** N) begin : g_bad_params
        $fatal(1, "contador_comparador_n: invalid N=%0d / MODULO=%0d", N, MODULO);
    end
    logic [N-1:0] q, q_next;
    logic         step;
    contador_mod_n #(.N(N), .MODULO(MODULO), .WRAP(WRAP)) u_cnt (
        .clock(clock), .zera(zera), .carrega(carrega), .conta(conta), .desce(desce),
        .chaves(chaves), .q(q), .q_next(q_next), .step(step), .fim(fim)
    );
    always_comb begin
        menor = q < chaves;
        maior = q > chaves;
        igual = q == chaves;
    end
    always_ff @(posedge clock)
        alcancou <= zera ? 1'b0 : step & (q_next == chaves);
    for (genvar k = 0; k < N / 4; k++) begin : g_dig
        hexa7seg u_seg (.hexa(q[4*k +: 4]), .display(db_contagem[DIGIT_W*k +: DIGIT_W]));
    end
endmodule

// File: tb/tb_contador_comparador_n.sv
// tb_contador_comparador_n: directed vector table plus wrap/saturate and reset corner sequences
module tb_contador_comparador_n;
    typedef struct {
        logic       zera, carrega, conta, desce;
        logic [7:0] chaves;
        logic [7:0] q;
        logic       menor, maior, igual, fim, alc;
    } vec_t;

    logic clock = 1'b0;
    logic zera, carrega, conta, desce;
    logic [7:0] chaves;
    logic menor, maior, igual, fim, alcancou;
    logic [13:0] db;
    logic s_menor, s_maior, s_igual, s_fim, s_alc;
    logic [13:0] s_db;
    int checks = 0;
    int failures = 0;
    logic [6:0] segs [16];
    vec_t vecs [18];

    always #5 clock = ~clock;

    contador_comparador_n #(.N(8), .MODULO(200), .WRAP(1'b1)) dut (
        .clock(clock), .zera(zera), .carrega(carrega), .conta(conta), .desce(desce),
        .chaves(chaves), .menor(menor), .maior(maior), .igual(igual), .fim(fim),
        .alcancou(alcancou), .db_contagem(db)
    );
    contador_comparador_n #(.N(8), .MODULO(200), .WRAP(1'b0)) dut_sat (
        .clock(clock), .zera(zera), .carrega(carrega), .conta(conta), .desce(desce),
        .chaves(chaves), .menor(s_menor), .maior(s_maior), .igual(s_igual), .fim(s_fim),
        .alcancou(s_alc), .db_contagem(s_db)
    );

    function automatic logic [13:0] disp(input logic [7:0] v);
        return {segs[v[7:4]], segs[v[3:0]]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic z, input logic c, input logic e, input logic d, input logic [7:0] ch);
        zera = z; carrega = c; conta = e; desce = d; chaves = ch;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        segs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0]  = '{1, 0, 0, 0, 8'h05, 8'd0,   1, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 8'h03, 8'd1,   1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 8'h03, 8'd2,   1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 8'h03, 8'd3,   0, 0, 1, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 8'h03, 8'd3,   0, 0, 1, 0, 0};
        vecs[5]  = '{0, 1, 1, 0, 8'hC7, 8'd199, 0, 0, 1, 1, 0};
        vecs[6]  = '{0, 0, 1, 0, 8'hC7, 8'd0,   1, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 8'hFA, 8'd199, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 0, 8'h05, 8'd5,   0, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 1, 1, 8'h03, 8'd4,   0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 1, 8'h03, 8'd3,   0, 0, 1, 0, 1};
        vecs[11] = '{0, 0, 1, 1, 8'h03, 8'd2,   1, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 1, 8'h02, 8'd2,   0, 0, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 8'hFF, 8'd2,   1, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 1, 0, 8'h03, 8'd3,   0, 0, 1, 0, 1};
        vecs[15] = '{1, 0, 1, 0, 8'h00, 8'd0,   0, 0, 1, 0, 0};
        vecs[16] = '{0, 0, 1, 1, 8'h00, 8'd199, 0, 1, 0, 0, 0};
        vecs[17] = '{0, 0, 1, 1, 8'hC6, 8'd198, 0, 0, 1, 0, 1};
        drive(0, 0, 0, 0, 8'h00);
        @(negedge clock);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].zera, vecs[i].carrega, vecs[i].conta, vecs[i].desce, vecs[i].chaves);
            tick();
            check($sformatf("v%0d db", i), 32'(db), 32'(disp(vecs[i].q)));
            check($sformatf("v%0d menor", i), 32'(menor), 32'(vecs[i].menor));
            check($sformatf("v%0d maior", i), 32'(maior), 32'(vecs[i].maior));
            check($sformatf("v%0d igual", i), 32'(igual), 32'(vecs[i].igual));
            check($sformatf("v%0d fim", i), 32'(fim), 32'(vecs[i].fim));
            check($sformatf("v%0d alcancou", i), 32'(alcancou), 32'(vecs[i].alc));
        end
        // wrap vs saturate at the bottom, then at the top
        drive(1, 0, 0, 0, 8'h00);
        tick();
        check("sat reset db", 32'(s_db), 32'(disp(8'd0)));
        drive(0, 0, 1, 1, 8'h00);
        #1;
        check("down fim wrap", 32'(fim), 32'd1);
        check("down fim sat", 32'(s_fim), 32'd1);
        tick();
        check("down wrap db", 32'(db), 32'(disp(8'd199)));
        check("down wrap maior", 32'(maior), 32'd1);
        check("down wrap alc", 32'(alcancou), 32'd0);
        check("down sat db", 32'(s_db), 32'(disp(8'd0)));
        check("down sat igual", 32'(s_igual), 32'd1);
        check("down sat alc", 32'(s_alc), 32'd0);
        check("down sat fim", 32'(s_fim), 32'd1);
        drive(0, 1, 0, 0, 8'hC7);
        tick();
        check("sat load db", 32'(s_db), 32'(disp(8'd199)));
        drive(0, 0, 1, 0, 8'hC7);
        tick();
        check("up sat db", 32'(s_db), 32'(disp(8'd199)));
        check("up sat alc", 32'(s_alc), 32'd0);
        check("up sat fim", 32'(s_fim), 32'd1);
        check("up sat maior", 32'(s_maior), 32'd0);
        check("up sat menor", 32'(s_menor), 32'd0);
        check("up wrap db", 32'(db), 32'(disp(8'd0)));
        check("up wrap alc", 32'(alcancou), 32'd0);
        // reset on the very edge a step would land on chaves
        drive(0, 1, 0, 0, 8'h0F);
        tick();
        check("pre-zera db", 32'(db), 32'(disp(8'h0F)));
        drive(1, 0, 1, 0, 8'h10);
        tick();
        check("zera step db", 32'(db), 32'(disp(8'd0)));
        check("zera step alc", 32'(alcancou), 32'd0);
        check("zera step menor", 32'(menor), 32'd1);
        drive(0, 0, 0, 0, 8'h10);
        tick();
        check("post zera alc", 32'(alcancou), 32'd0);
        check("post zera db", 32'(db), 32'(disp(8'd0)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
